seg_display_scheduler: RTL and testbench

Scan controller and source arbiter for the 4-digit seven-segment display of the digital lock. Time-multiplexes the digits with a programmable slot period and inter-digit blanking. Shares the display between two requesters: the keypad entry echo (4-digit shift buffer) and the lock status message (OPEN / Err), with status having priority for a fixed hold time. Sits between the lock FSM / keypad logic and the display pins.

---
 rtl/seg_display_scheduler.sv | 127 ++++++++++++
 tb/tb_seg_display_scheduler.sv | 128 ++++++++++++
 2 files changed

// File: rtl/seg_display_scheduler.sv
// seg_display_scheduler: 4-digit seven-segment scan and entry/status source arbiter.
// Define SEG_BLANKING_EN to blank all digits for the first BLANK_CYCLES of each slot.
module seg_display_scheduler #(
  parameter int CLK_DIV      = 1000,
  parameter int BLANK_CYCLES = 8,
  parameter int HOLD_FRAMES  = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       entry_valid,
  input  logic [3:0] entry_digit,
  output logic       entry_ready,
  input  logic       entry_clear,
  input  logic       status_req,
  input  logic [3:0] status_code,
  output logic       status_ack,
  output logic       busy,
  output logic       seg_src,
  output logic [1:0] slot,
  output logic [3:0] dig,
  output logic [6:0] glyph
);
  localparam int PW = $clog2(CLK_DIV);
  localparam int HW = $clog2(HOLD_FRAMES) + 1;
  typedef enum logic [1:0] {ENTRY, PEND, STATUS} state_t;
  if (CLK_DIV < 2 || BLANK_CYCLES >= CLK_DIV || HOLD_FRAMES < 1) begin : g_bad
    $error("seg_display_scheduler: illegal parameters");
  end
  logic [PW-1:0] pcnt;
  logic [HW-1:0] hold;
  logic [15:0]   ent;
  logic [3:0]    vld, code, disp, sel;
  logic          tc, frame, push, fresh;
  state_t        state;
  assign tc          = pcnt == PW'(CLK_DIV - 1);
  assign frame       = tc & (slot == 2'd3);
  assign entry_ready = ~&vld;
  assign push        = entry_valid & entry_ready;
  assign busy        = state != ENTRY;
  assign seg_src     = state == STATUS;
  assign sel         = ~(4'b0001 << slot);
`ifdef SEG_BLANKING_EN
  assign dig = (32'(pcnt) < BLANK_CYCLES) ? 4'b1111 : sel;
`else
  assign dig = sel;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt <= '0;
      slot <= '0;
    end else begin
      pcnt <= tc ? '0 : pcnt + 1'b1;
      if (tc) slot <= slot + 2'd1;
    end
  end
  // newest digit enters position 3; older ones slide toward position 0
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
    end else if (push) begin
      vld <= entry_clear ? 4'b1000 : {1'b1, vld[3:1]};
      ent <= {entry_digit, ent[15:4]};
    end else if (entry_clear) begin
      vld <= '0;
    end
  end
  // a retrigger while showing waits in code/fresh so the current frame is never mixed
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ENTRY;
      code       <= '0;
      disp       <= '0;
      fresh      <= 1'b0;
      hold       <= '0;
      status_ack <= 1'b0;
    end else begin
      status_ack <= status_req;
      if (status_req) begin
        code <= status_code;
        hold <= '0;
        if (state == ENTRY) state <= PEND;
        if (state == STATUS) begin
          if (frame) disp <= status_code;
          fresh <= ~frame;
        end
      end else if (frame && state == PEND) begin
        state <= STATUS;
        disp  <= code;
        hold  <= '0;
      end else if (frame && state == STATUS) begin
        if (fresh) begin
          disp  <= code;
          fresh <= 1'b0;
          hold  <= '0;
        end else if (hold == HW'(HOLD_FRAMES - 1)) begin
          state <= ENTRY;
        end else begin
          hold <= hold + 1'b1;
        end
      end
    end
  end
  function automatic logic [6:0] dec_seg(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1111110;
      4'd1:    return 7'b0110000;
      4'd2:    return 7'b1101101;
      4'd3:    return 7'b1111001;
      4'd4:    return 7'b0110011;
      4'd5:    return 7'b1011011;
      4'd6:    return 7'b1011111;
      4'd7:    return 7'b1110000;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1111011;
      default: return 7'b0000001;
    endcase
  endfunction
  function automatic logic [6:0] stat_seg(input logic [3:0] c, input logic [1:0] s);
    logic [27:0] t;
    t = (c == 4'b1111) ? {7'b0010101, 7'b1001111, 7'b1100111, 7'b1111110} :
        (c == 4'b1000) ? {7'b0000101, 7'b0000101, 7'b1001111, 7'b0000000} : '0;
    return t[7*s +: 7];
  endfunction
  always_comb begin
    glyph = seg_src ? stat_seg(disp, slot) : vld[slot] ? dec_seg(ent[{slot, 2'b00} +: 4]) : 7'b0000000;
  end
endmodule

// File: tb/tb_seg_display_scheduler.sv
// tb_seg_display_scheduler: random and directed stimulus checked against a frame-level behavioural model.
module tb_seg_display_scheduler;
  localparam int CD = 4, BC = 1, HF = 2;
  logic clk = 1'b0, rst = 1'b1, entry_valid = 1'b0, entry_clear = 1'b0, status_req = 1'b0;
  logic [3:0] entry_digit = '0, status_code = '0;
  logic entry_ready, status_ack, busy, seg_src;
  logic [1:0] slot;
  logic [3:0] dig;
  logic [6:0] glyph;
  seg_display_scheduler #(.CLK_DIV(CD), .BLANK_CYCLES(BC), .HOLD_FRAMES(HF)) dut (
    .clk(clk), .rst(rst), .entry_valid(entry_valid), .entry_digit(entry_digit),
    .entry_ready(entry_ready), .entry_clear(entry_clear), .status_req(status_req),
    .status_code(status_code), .status_ack(status_ack), .busy(busy), .seg_src(seg_src),
    .slot(slot), .dig(dig), .glyph(glyph)
  );
  always #5 clk = ~clk;
  int tests = 0, fails = 0;
  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  // model: cycle count since reset, digit queue, and status as shown/waiting messages
  int t, shown, want_code, left;
  int q[$];
  bit showing, want, ack_m, known = 1'b0;
  int dec_t[10] = '{'h7e, 'h30, 'h6d, 'h79, 'h33, 'h5b, 'h5f, 'h70, 'h7f, 'h7b};
  int open_t[4] = '{'h7e, 'h67, 'h4f, 'h15};
  int closed_t[4] = '{'h00, 'h4f, 'h05, 'h05};
  function automatic int m_glyph();
    int s = (t / CD) % 4;
    int n = q.size();
    if (showing) return shown == 15 ? open_t[s] : shown == 8 ? closed_t[s] : 0;
    if (s < 4 - n) return 0;
    return q[s-(4-n)] > 9 ? 1 : dec_t[q[s-(4-n)]];
  endfunction
  function automatic int m_dig();
    int s = (t / CD) % 4;
`ifdef SEG_BLANKING_EN
    if (t % CD < BC) return 15;
`endif
    return 15 & ~(1 << s);
  endfunction
  task automatic compare();
    if (!known) return;
    check("slot", slot, (t / CD) % 4);
    check("dig", dig, m_dig());
    check("glyph", glyph, m_glyph());
    check("seg_src", seg_src, showing);
    check("busy", busy, showing || want);
    check("entry_ready", entry_ready, q.size() < 4);
    check("status_ack", status_ack, ack_m);
  endtask
  task automatic step(input bit r, input bit ev, input int ed, input bit ec, input bit sr, input int sc);
    bit frame, rdy;
    if (r) begin
      t = 0; q.delete(); showing = 0; want = 0; ack_m = 0; known = 1;
      return;
    end
    frame = (t % (4 * CD)) == 4 * CD - 1;
    rdy = q.size() < 4;
    if (ec) q.delete();
    if (ev && rdy) q.push_back(ed);
    ack_m = sr;
    if (sr) begin
      if (showing && frame) begin
        shown = sc; left = HF; want = 0;
      end else begin
        want = 1; want_code = sc;
      end
    end else if (frame) begin
      if (want) begin
        showing = 1; shown = want_code; left = HF; want = 0;
      end else if (showing) begin
        left--;
        if (left == 0) showing = 0;
      end
    end
    t++;
  endtask
  task automatic cyc(input bit r, input bit ev, input int ed, input bit ec, input bit sr, input int sc);
    @(negedge clk);
    compare();
    rst = r; entry_valid = ev; entry_digit = 4'(ed); entry_clear = ec;
    status_req = sr; status_code = 4'(sc);
    @(posedge clk);
    step(r, ev, ed, ec, sr, sc);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    idle(32);
    for (int d = 1; d <= 4; d++) cyc(0, 1, d, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 5, 0, 0, 0);
    idle(16);
    cyc(0, 0, 0, 1, 0, 0);
    for (int d = 1; d <= 3; d++) cyc(0, 1, d, 0, 0, 0);
    cyc(0, 1, 7, 1, 0, 0);
    idle(16);
    cyc(0, 1, 12, 0, 0, 0);
    idle(6);
    cyc(0, 0, 0, 0, 1, 15);
    idle(50);
    cyc(0, 0, 0, 0, 1, 15);
    idle(24);
    cyc(0, 0, 0, 0, 1, 8);
    idle(50);
    cyc(0, 0, 0, 0, 1, 15);
    idle(22);
    cyc(1, 0, 0, 0, 0, 0);
    idle(20);
    for (int i = 0; i < 3000; i++) begin
      int k = $urandom_range(0, 2);
      cyc($urandom_range(0, 499) == 0, $urandom_range(0, 1), $urandom_range(0, 15),
          $urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0,
          k == 0 ? 8 : k == 1 ? 15 : $urandom_range(0, 15));
    end
    @(negedge clk);
    compare();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
